// File: rtl/jam_result_collector.sv
// jam_result_collector: sequences JAM solver runs and queues run-tagged results in a FIFO.
// Optional JAM_TIMEOUT_EN: a stuck WAIT_RES is abandoned after TIMEOUT cycles with an err=1 entry.
module jam_result_collector #(
    parameter int DEPTH      = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 45000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [7:0]  num_runs,
    input  logic        jam_valid,
    input  logic [9:0]  jam_mincost,
    input  logic [3:0]  jam_matchcount,
    output logic        jam_rst,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [22:0] out_data
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, RESET_JAM, WAIT_RES, PUSH, DONE} state_t;

    state_t        state, state_nx;
    logic [7:0]    rcnt, run_id, runs;
    logic [9:0]    cost;
    logic [3:0]    mcnt;
    logic          err;
    logic [22:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          full, wr, rd, hit, tmo, last;

    assign full      = cnt == (AW+1)'(DEPTH);
    assign out_valid = cnt != '0;
    assign rd        = out_valid && out_ready;
    assign wr        = state == PUSH && !full;
    assign hit       = state == WAIT_RES && jam_valid;
    assign last      = run_id == runs - 8'd1;
    assign out_data  = out_valid ? mem[rp] : '0;

`ifdef JAM_TIMEOUT_EN
    logic [15:0] tcnt;

    always_ff @(posedge CLK) begin
        if (!RST_N || state != WAIT_RES)
            tcnt <= '0;
        else
            tcnt <= tcnt + 16'd1;
    end

    assign tmo = state == WAIT_RES && !jam_valid && tcnt == 16'(TIMEOUT - 1);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        jam_rst  = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:      if (start) state_nx = num_runs != 8'd0 ? RESET_JAM : DONE;
            RESET_JAM: begin
                busy = 1'b1;
                if (rcnt == 8'(RST_CYCLES - 1)) state_nx = WAIT_RES;
            end
            WAIT_RES:  begin
                jam_rst = 1'b0;
                busy    = 1'b1;
                if (hit || tmo) state_nx = PUSH;
            end
            PUSH:      begin
                jam_rst = 1'b0;
                busy    = 1'b1;
                if (!full) state_nx = last ? DONE : RESET_JAM;
            end
            DONE:      begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rcnt   <= '0;
            run_id <= '0;
            runs   <= '0;
            cost   <= '0;
            mcnt   <= '0;
            err    <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
        end else begin
            rcnt <= state == RESET_JAM ? rcnt + 8'd1 : 8'd0;
            if (state == IDLE && start) begin
                runs   <= num_runs;
                run_id <= '0;
            end
            if (hit || tmo) begin
                cost <= hit ? jam_mincost : 10'd1023;
                mcnt <= hit ? jam_matchcount : 4'd0;
                err  <= !hit;
            end
            if (wr) begin
                wp <= wp + AW'(1);
                if (!last) run_id <= run_id + 8'd1;
            end
            if (rd) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    // storage needs no reset: out_data is gated by the occupancy count
    always_ff @(posedge CLK) begin
        if (wr) mem[wp] <= {err, run_id, cost, mcnt};
    end
endmodule

// File: tb/tb_jam_result_collector.sv
// tb_jam_result_collector: directed checks of run sequencing, FIFO back-pressure and reset abort.
// Built with or without JAM_TIMEOUT_EN; the timeout scenario adapts to the macro.
module tb_jam_result_collector;
    logic        CLK = 0, RST_N = 0, start = 0, jam_valid = 0, out_ready = 0;
    logic [7:0]  num_runs = 0;
    logic [9:0]  jam_mincost = 0;
    logic [3:0]  jam_matchcount = 0;
    logic        jam_rst, busy, done, out_valid;
    logic [22:0] out_data;

    int checks = 0, failures = 0, done_cnt = 0, d0 = 0;
    int sc = 0, delay = 100, nrun = 0, max_valids = 1000, cost_base = 312, mc_base = 2;

    always #5 CLK = ~CLK;

    jam_result_collector #(.DEPTH(4), .RST_CYCLES(2), .TIMEOUT(50)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .num_runs(num_runs),
        .jam_valid(jam_valid), .jam_mincost(jam_mincost), .jam_matchcount(jam_matchcount),
        .jam_rst(jam_rst), .busy(busy), .done(done), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    // solver model: raises Valid `delay` cycles after reset release, holds it until reset
    always @(negedge CLK) begin
        if (done) done_cnt++;
        if (jam_rst) begin
            sc = 0;
            jam_valid = 0;
        end else if (!jam_valid && nrun < max_valids) begin
            sc++;
            if (sc == delay) begin
                jam_valid      = 1;
                jam_mincost    = 10'(cost_base + 3 * nrun);
                jam_matchcount = 4'(mc_base + nrun);
                nrun++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic pulse_start(input int n);
        num_runs = 8'(n);
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_jam(input int budget);
        int i = 0;
        while (!jam_valid && i < budget) begin
            tick(1);
            i++;
        end
        check("jam_valid_seen", 32'(jam_valid), 1);
    endtask

    task automatic wait_out(input int budget);
        int i = 0;
        while (!out_valid && i < budget) begin
            tick(1);
            i++;
        end
        check("out_valid_seen", 32'(out_valid), 1);
    endtask

    initial begin
        tick(3);
        check("rst_jam_rst", 32'(jam_rst), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        RST_N = 1;
        tick(1);

        // single run, 100-cycle solver, latency and field packing
        d0 = done_cnt;
        pulse_start(1);
        check("t1_busy", 32'(busy), 1);
        check("t1_rst_a", 32'(jam_rst), 1);
        tick(1);
        check("t1_rst_b", 32'(jam_rst), 1);
        tick(1);
        check("t1_rst_low", 32'(jam_rst), 0);
        wait_jam(200);
        check("t1_lat0", 32'(out_valid), 0);
        tick(1);
        check("t1_lat1", 32'(out_valid), 0);
        tick(1);
        check("t1_lat2", 32'(out_valid), 1);
        check("t1_data", 32'(out_data), 32'h1382);
        check("t1_done", 32'(done), 1);
        check("t1_busy_low", 32'(busy), 0);
        tick(1);
        check("t1_done_once", 32'(done), 0);
        check("t1_idle_rst", 32'(jam_rst), 1);
        check("t1_done_cnt", 32'(done_cnt - d0), 1);
        out_ready = 1;
        tick(1);
        check("t1_drained", 32'(out_valid), 0);
        out_ready = 0;

        // six runs into a four-deep FIFO with the consumer stalled
        nrun = 0; cost_base = 100; mc_base = 0; delay = 3;
        d0 = done_cnt;
        pulse_start(6);
        tick(100);
        check("t2_stall_jam_rst", 32'(jam_rst), 0);
        check("t2_stall_busy", 32'(busy), 1);
        check("t2_stall_valid", 32'(out_valid), 1);
        check("t2_no_done", 32'(done_cnt - d0), 0);
        pulse_start(2);
        out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            wait_out(100);
            check($sformatf("t2_entry%0d", k), 32'(out_data),
                  32'({1'b0, 8'(k), 10'(100 + 3 * k), 4'(k)}));
            tick(1);
        end
        tick(30);
        check("t2_empty", 32'(out_valid), 0);
        check("t2_busy_low", 32'(busy), 0);
        check("t2_done_cnt", 32'(done_cnt - d0), 1);
        out_ready = 0;

        // zero-run batch, plus a start coincident with its done pulse
        d0 = done_cnt;
        pulse_start(0);
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 0);
        pulse_start(1);
        check("t3_done_once", 32'(done), 0);
        check("t3_start_ignored", 32'(busy), 0);
        tick(5);
        check("t3_busy_stays", 32'(busy), 0);
        check("t3_no_entry", 32'(out_valid), 0);
        check("t3_done_cnt", 32'(done_cnt - d0), 1);

        // reset during WAIT_RES of the third run, then a fresh batch
        nrun = 0; max_valids = 2; delay = 3; cost_base = 50; mc_base = 1;
        pulse_start(3);
        tick(60);
        check("t4_wait_jam_rst", 32'(jam_rst), 0);
        check("t4_wait_busy", 32'(busy), 1);
        check("t4_wait_fifo", 32'(out_valid), 1);
        RST_N = 0;
        tick(1);
        check("t4_rst_jam_rst", 32'(jam_rst), 1);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_fifo", 32'(out_valid), 0);
        check("t4_rst_data", 32'(out_data), 0);
        RST_N = 1;
        tick(1);
        nrun = 0; max_valids = 1000; cost_base = 7; mc_base = 5;
        pulse_start(1);
        wait_out(200);
        check("t4_restart_data", 32'(out_data), 32'h75);
        check("t4_restart_done", 32'(done), 1);
        out_ready = 1;
        tick(1);
        out_ready = 0;
        check("t4_drained", 32'(out_valid), 0);

        // solver never answers
        nrun = 0; max_valids = 0;
        pulse_start(1);
        tick(2);
        check("t5_wait", 32'(jam_rst), 0);
`ifdef JAM_TIMEOUT_EN
        tick(49);
        check("t5_pre_timeout", 32'(out_valid), 0);
        tick(1);
        check("t5_push", 32'(out_valid), 0);
        tick(1);
        check("t5_entry_valid", 32'(out_valid), 1);
        check("t5_entry_data", 32'(out_data), 32'h403FF0);
        check("t5_done", 32'(done), 1);
`else
        tick(300);
        check("t5_still_waiting", 32'(jam_rst), 0);
        check("t5_still_busy", 32'(busy), 1);
        check("t5_no_entry", 32'(out_valid), 0);
        RST_N = 0;
        tick(1);
        RST_N = 1;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
